pe_output_writer: RTL and testbench

PE_OUTPUT_WRITER -- requirements
Module: pe_output_writer

---
 rtl/pe_output_writer_if.sv | 35 +++
 rtl/pe_output_writer.sv | 146 ++++++++++++++
 tb/tb_pe_output_writer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_output_writer_if.sv
// PE output writer bus: tile handshake from the PE array, write port to memory.
// Ports: tile_* / size_type / *_index / total_width / acc_count (tile side),
//        mem_* (write side), busy / tile_done (status).
interface pe_output_writer_if #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 16
);
    logic                            tile_valid;
    logic                            tile_ready;
    logic [5:0][5:0][DATA_W-1:0]     tile_data;
    logic                            size_type;
    logic [8:0]                      row_index;
    logic [8:0]                      col_index;
    logic [8:0]                      total_width;
    logic [7:0]                      acc_count;
    logic                            mem_wr_en;
    logic [ADDR_W-1:0]               mem_addr;
    logic signed [ACC_W-1:0]         mem_wr_data;
    logic                            mem_ready;
    logic                            busy;
    logic                            tile_done;

    modport master (
        output tile_valid, tile_data, size_type, row_index, col_index,
        output total_width, acc_count, mem_ready,
        input  tile_ready, mem_wr_en, mem_addr, mem_wr_data, busy, tile_done
    );

    modport slave (
        input  tile_valid, tile_data, size_type, row_index, col_index,
        input  total_width, acc_count, mem_ready,
        output tile_ready, mem_wr_en, mem_addr, mem_wr_data, busy, tile_done
    );
endinterface

// File: rtl/pe_output_writer.sv
// Accumulates acc_count PE tiles with saturation, then drains NxN to memory.
// Ports: clk, reset (async, active-high), bus (pe_output_writer_if.slave).
module pe_output_writer #(
    parameter int DATA_W = 12,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pe_output_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state_q, state_d;

    logic signed [ACC_W-1:0] acc [6][6];
    logic                    size_q;
    logic [8:0]              row_q;
    logic [8:0]              col_q;
    logic [8:0]              width_q;
    logic [7:0]              grp_q;
    logic [7:0]              cnt_q;
    logic [2:0]              r_q;
    logic [2:0]              c_q;
    logic                    done_q;
    logic                    done_d;

    logic       xfer;
    logic       wr_acc;
    logic       last_elem;
    logic [2:0] last_idx;
    logic [7:0] eff_cnt;
    logic [7:0] cnt_inc;
    logic [ADDR_W-1:0] row_sum;
    logic [ADDR_W-1:0] addr;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // Sign of the extra bit disagrees with the MSB only on overflow.
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    assign bus.tile_ready = (state_q != DRAIN);
    assign bus.busy       = (state_q != IDLE);
    assign bus.tile_done  = done_q;
    assign bus.mem_wr_en  = (state_q == DRAIN);

    assign xfer      = bus.tile_valid && bus.tile_ready;
    assign wr_acc    = (state_q == DRAIN) && bus.mem_ready;
    assign last_idx  = size_q ? 3'd3 : 3'd5;
    assign last_elem = (r_q == last_idx) && (c_q == last_idx);
    assign eff_cnt   = (bus.acc_count == 8'd0) ? 8'd1 : bus.acc_count;
    assign cnt_inc   = cnt_q + 8'd1;

    // Modular arithmetic: truncating operands first keeps the low ADDR_W bits exact.
    assign row_sum = ADDR_W'(row_q) + ADDR_W'(r_q);
    assign addr    = row_sum * ADDR_W'(width_q) + ADDR_W'(col_q) + ADDR_W'(c_q);

    assign bus.mem_addr    = (state_q == DRAIN) ? addr : '0;
    assign bus.mem_wr_data = (state_q == DRAIN) ? acc[r_q][c_q] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer)
                    state_d = (eff_cnt == 8'd1) ? DRAIN : ACCUM;
            end
            ACCUM: begin
                if (xfer && cnt_inc == grp_q)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (wr_acc && last_elem) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    acc[r][c] <= '0;
            size_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            width_q <= '0;
            grp_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            if (xfer) begin
                if (state_q == IDLE) begin
                    for (int r = 0; r < 6; r++)
                        for (int c = 0; c < 6; c++)
                            acc[r][c] <= ACC_W'($signed(bus.tile_data[r][c]));
                    size_q  <= bus.size_type;
                    row_q   <= bus.row_index;
                    col_q   <= bus.col_index;
                    width_q <= bus.total_width;
                    grp_q   <= eff_cnt;
                    cnt_q   <= 8'd1;
                end else begin
                    for (int r = 0; r < 6; r++)
                        for (int c = 0; c < 6; c++)
                            acc[r][c] <= sat_add(acc[r][c],
                                ACC_W'($signed(bus.tile_data[r][c])));
                    cnt_q <= cnt_inc;
                end
            end
            if (wr_acc) begin
                if (c_q == last_idx) begin
                    c_q <= 3'd0;
                    r_q <= (r_q == last_idx) ? 3'd0 : r_q + 3'd1;
                end else begin
                    c_q <= c_q + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_output_writer.sv
// Randomized scoreboard bench for pe_output_writer.
// Stimulus pushes expected writes; a negedge monitor pops and compares.
module tb_pe_output_writer;
    localparam int DATA_W = 12;
    localparam int ACC_W  = 12;
    localparam int ADDR_W = 16;

    typedef struct {
        int addr;
        int data;
        bit last;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pe_output_writer_if #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) bus ();

    pe_output_writer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_wr  = 0;
    bit  done_exp   = 1'b0;
    bit  prev_stall = 1'b0;
    int  prev_addr  = 0;
    int  prev_data  = 0;
    int  ready_mode = 0;
    int  ready_ph   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        int lo;
        int hi;
        lo = -(1 << (ACC_W - 1));
        hi = (1 << (ACC_W - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int gen(input int mode, input int cval, input int r, input int c);
        case (mode)
            0: return cval;
            1: return r * 6 + c;
            2: return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
            default: return int'($urandom_range(0, 400)) - 200;
        endcase
    endfunction

    // Memory back-pressure, changed just after each rising edge.
    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: bus.mem_ready = 1'b1;
                1: begin
                    bus.mem_ready = pat[ready_ph];
                    ready_ph = (ready_ph + 1) % 4;
                end
                default: bus.mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected writes and checks timing side effects.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_exp   = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            check("tile_done", longint'(bus.tile_done), longint'(done_exp));
            if (done_exp)
                check("ready_after_done", longint'(bus.tile_ready), 1);
            done_exp = 1'b0;
            if (prev_stall) begin
                check("stall_en", longint'(bus.mem_wr_en), 1);
                check("stall_addr", longint'(bus.mem_addr), longint'(prev_addr));
                check("stall_data", longint'($signed(bus.mem_wr_data)), longint'(prev_data));
            end
            if (bus.mem_wr_en) begin
                check("drain_ready", longint'(bus.tile_ready), 0);
                check("drain_busy", longint'(bus.busy), 1);
                if (bus.mem_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                                 bus.mem_addr, $signed(bus.mem_wr_data));
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", longint'(bus.mem_addr), longint'(e.addr));
                        check("wr_data", longint'($signed(bus.mem_wr_data)), longint'(e.data));
                        done_exp = e.last;
                        n_wr++;
                    end
                end
            end
            prev_stall = bus.mem_wr_en && !bus.mem_ready;
            prev_addr  = int'(bus.mem_addr);
            prev_data  = int'($signed(bus.mem_wr_data));
        end
    end

    // Drives one accumulation group; caller is at a falling edge.
    task automatic send_group(input int accn, input bit sz, input int row,
                              input int col, input int width,
                              input int mode, input int cval);
        int  eff;
        int  n;
        int  v;
        int  wait_n;
        int  acc [6][6];
        wr_t e;
        eff = (accn == 0) ? 1 : accn;
        n   = sz ? 4 : 6;
        for (int k = 0; k < eff; k++) begin
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++) begin
                    v = gen(mode, cval, r, c);
                    bus.tile_data[r][c] = DATA_W'(v);
                    acc[r][c] = (k == 0) ? v : sat(acc[r][c] + v);
                end
            if (k == 0) begin
                bus.size_type   = sz;
                bus.row_index   = 9'(row);
                bus.col_index   = 9'(col);
                bus.total_width = 9'(width);
                bus.acc_count   = 8'(accn);
            end else begin
                bus.size_type   = 1'($urandom_range(0, 1));
                bus.row_index   = 9'($urandom_range(0, 511));
                bus.col_index   = 9'($urandom_range(0, 511));
                bus.total_width = 9'($urandom_range(0, 511));
                bus.acc_count   = 8'($urandom_range(0, 255));
            end
            if (k == eff - 1)
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++) begin
                        e.addr = ((row + r) * width + col + c) % (1 << ADDR_W);
                        e.data = acc[r][c];
                        e.last = (r == n - 1) && (c == n - 1);
                        exp_q.push_back(e);
                    end
            bus.tile_valid = 1'b1;
            wait_n = 0;
            while (!bus.tile_ready && wait_n < 2000) begin
                @(negedge clk);
                wait_n++;
            end
            if (!bus.tile_ready) begin
                n_cmp++;
                n_err++;
                $display("FAIL tile_accept_timeout: tile_ready %0b, required 1", bus.tile_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.tile_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d writes pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        reset            = 1'b1;
        bus.tile_valid   = 1'b0;
        bus.tile_data    = '0;
        bus.size_type    = 1'b0;
        bus.row_index    = '0;
        bus.col_index    = '0;
        bus.total_width  = '0;
        bus.acc_count    = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", longint'(bus.mem_wr_en), 0);
        check("rst_addr", longint'(bus.mem_addr), 0);
        check("rst_data", longint'(bus.mem_wr_data), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.tile_done), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", longint'(bus.tile_ready), 1);
        check("rel_busy", longint'(bus.busy), 0);

        ready_mode = 0;
        send_group(1, 1'b1, 2, 3, 10, 0, 5);
        wait_idle();
        send_group(3, 1'b0, 1, 1, 20, 1, 0);
        wait_idle();
        send_group(2, 1'b0, 0, 0, 6, 0, 2047);
        send_group(2, 1'b1, 7, 2, 40, 0, -2048);
        wait_idle();

        ready_mode = 1;
        ready_ph   = 0;
        send_group(1, 1'b0, 4, 5, 30, 2, 0);
        wait_idle();

        ready_mode = 0;
        base = n_wr;
        send_group(1, 1'b0, 0, 0, 16, 3, 0);
        k = 0;
        while (n_wr < base + 5 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("pre_reset_writes", longint'(n_wr - base), 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en", longint'(bus.mem_wr_en), 0);
        check("mid_rst_busy", longint'(bus.busy), 0);
        check("mid_rst_done", longint'(bus.tile_done), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", longint'(bus.tile_ready), 1);
        send_group(0, 1'b0, 3, 9, 50, 2, 0);
        wait_idle();

        ready_mode = 2;
        for (int g = 0; g < 20; g++)
            send_group(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                       int'($urandom_range(1, 511)),
                       int'($urandom_range(2, 3)), 0);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
